stim_resp_engine: RTL and testbench
===================================

Name: stim_resp_engine

Overview:
- Synthesisable, parametrised successor to our fixed-vector stimulus benches.
- Drives a generated stimulus vector of any width into a DUT and holds it for a programmable settle time.
- Folds the DUT response into a MISR signature once per vector.
- Lets fuzz runs compare synthesised netlists on-chip or in simulation by signature instead of a textual $strobe dump.

Parameters:
- IN_W, 83, total stimulus width (concatenation of all DUT inputs, MSB = first input).
- OUT_W, 245, DUT response width.
- HOLD, 1, cycles each vector is held before capture (>=1).
- CNT_W, 16, width of vector count.
- SIG_INIT, 32'hFFFFFFFF, MISR reset/start value.
- SIG_POLY, 32'h04C11DB7, MISR feedback polynomial.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- seed  in  64  LFSR seed; 0 is replaced by 64'h1
- num_vec  in  CNT_W  vectors per run, including the all-zero vector 0
- stim  out  IN_W  stimulus to DUT
- resp  in  OUT_W  DUT response
- busy  out  1  high from the accept edge until DONE exits
- done  out  1  one-cycle pulse at end of run
- vec_cnt  out  CNT_W  index of the vector currently applied
- signature  out  32  MISR value; stable from done until next start

Behaviour:
- Reset values:
  - stim = 0, signature = SIG_INIT, vec_cnt = 0, busy = 0, done = 0.
  - LFSR state s = 64'h1; FSM enters IDLE. Reset mid-run aborts immediately, with no done pulse.
- FSM states: IDLE, SETTLE, CAPTURE, DONE.
- IDLE:
  - start=1 with num_vec!=0: load s = seed (or 1), set stim = 0, vec_cnt = 0, signature = SIG_INIT, hold counter = HOLD-1, then go to SETTLE.
  - start with num_vec = 0 is ignored (no busy, no done).
- SETTLE: decrement the hold counter; at 0, go to CAPTURE. SETTLE lasts exactly HOLD cycles.
- CAPTURE (1 cycle):
  - fold(resp) = XOR of 32-bit chunks of resp, with the top chunk zero-padded.
  - signature <= {signature[30:0],1'b0} ^ (signature[31] ? SIG_POLY : 0) ^ fold(resp).
  - If vec_cnt == num_vec-1: go to DONE.
  - Otherwise: advance s one step (Fibonacci, taps 64,63,61,60, new bit into LSB), then set stim = gen(s_next), vec_cnt++, and go to SETTLE.
- gen(s): 64-bit chunk k (k = 0 at LSB) = rotl(s, 7*k) ^ k. Concatenate the chunks and truncate to IN_W bits.
- DONE (1 cycle): done = 1, busy still 1; next state IDLE. stim keeps its last value until the next accept.
- Timing: one vector takes HOLD+1 cycles. done is high in the cycle that begins num_vec*(HOLD+1) edges after the accept edge.
- num_vec and seed are sampled only at accept; changes during a run have no effect.
- start during a run is ignored.
- vec_cnt never wraps, because the run terminates at num_vec-1.

Optional Feature:
- Macro: STIM_RESP_DUAL_EN.
- When defined, adds these ports:
  - resp_b in OUT_W, second DUT (e.g. post-synthesis netlist).
  - signature_b out 32, same MISR over resp_b.
  - mismatch out 1, sticky; set in any CAPTURE where resp != resp_b; cleared at accept and at reset.
  - first_bad out CNT_W, vec_cnt of the first mismatching capture; reset 0.
- When not defined, these ports and their logic are absent and the block behaves as above.

Decomposition:
- Package stim_resp_pkg holds: the FSM state enum, SIG_INIT/SIG_POLY defaults, LFSR tap constants, and function fold32 (parametrised by width via a local loop).
- One sub-module, stim_misr32 (fold plus shift/feedback, with en and load), instantiated once, or twice under STIM_RESP_DUAL_EN.
- The LFSR and gen() stay inline.

Test Plan:
- Single vector: rst, then start with num_vec=1, HOLD=4, resp held 0 -> stim = 0 throughout; done pulses 5 edges after accept; signature = 32'hFB3EE249.
- Null run: start with num_vec=0 -> busy and done stay 0 for 20 cycles; signature stays 32'hFFFFFFFF.
- Generation: seed=64'h1, num_vec=2, HOLD=1, IN_W=83 -> vector 1 stim equals gen() of the stepped LFSR (chunk0 = 64'h2); vec_cnt steps 0 then 1; done 4 edges after accept.
- Abort and repeatability: assert rst at vector 10 of a 21-vector run -> all outputs return to reset values with no done pulse. Rerun with the same seed and resp = stim-derived model -> identical signature in two back-to-back runs.
- Ignored inputs: start and num_vec toggled mid-run -> no effect on vec_cnt progression or the done time.
- Dual (STIM_RESP_DUAL_EN): resp_b = resp except bit 0 flipped at vec 3 -> mismatch = 1, first_bad = 3, signature_b != signature; clean rerun -> mismatch = 0.

Source files
------------

// File: rtl/stim_resp_pkg.sv
// Shared types and constants for the stimulus/response engine: FSM state
// encoding, MISR defaults, LFSR feedback taps and the response fold helper.
package stim_resp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_CAPTURE,
      ST_DONE
   } state_e;

   localparam logic [31:0] SIG_INIT_DEF = 32'hFFFFFFFF;
   localparam logic [31:0] SIG_POLY_DEF = 32'h04C11DB7;

   // Fibonacci taps 64,63,61,60 expressed as bit indices 63,62,60,59.
   localparam logic [63:0] LFSR_TAP_MASK = 64'hD800_0000_0000_0000;

   // Widest response fold32 accepts; callers zero-extend into this width.
   localparam int FOLD_MAX_W = 2048;

   // XOR of the 32-bit chunks of the low 'width' bits; the top chunk is
   // zero-padded because the caller zero-extends the data.
   function automatic logic [31:0] fold32(input logic [FOLD_MAX_W-1:0] data,
                                          input int width);
      logic [31:0] acc;
      acc = '0;
      for (int i = 0; i < FOLD_MAX_W / 32; i++) begin
         if (i * 32 < width) acc ^= data[i*32 +: 32];
      end
      return acc;
   endfunction

endpackage

// File: rtl/stim_misr32.sv
// 32-bit MISR: folds a wide response to 32 bits and shifts it into the
// signature with polynomial feedback. load restarts from SIG_INIT and takes
// priority over en.
module stim_misr32
   import stim_resp_pkg::*;
#(
   parameter int          DATA_W   = 245,
   parameter logic [31:0] SIG_INIT = SIG_INIT_DEF,
   parameter logic [31:0] SIG_POLY = SIG_POLY_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              en_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [31:0]       sig_o
);

   logic [FOLD_MAX_W-1:0] data_ext;
   logic [31:0]           sig_q;
   logic [31:0]           sig_d;

   // Next signature: shift, conditional feedback, fold of the response.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      data_ext = '0;
      data_ext[DATA_W-1:0] = data_i;
      sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? SIG_POLY : 32'h0)
              ^ fold32(data_ext, DATA_W);
   end

   // Signature register with restart and capture enable.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      if (rst || load_i) sig_q <= SIG_INIT;
      else if (en_i)     sig_q <= sig_d;
   end

   assign sig_o = sig_q;

endmodule

// File: rtl/stim_resp_engine.sv
// Stimulus/response engine: drives LFSR-generated vectors into a DUT, holds
// each for HOLD cycles, then folds the response into a MISR signature.
// Optional build macro STIM_RESP_DUAL_EN adds a second response input with
// its own signature and a sticky mismatch flag for netlist comparison.
module stim_resp_engine
   import stim_resp_pkg::*;
#(
   parameter int          IN_W     = 83,
   parameter int          OUT_W    = 245,
   parameter int          HOLD     = 1,
   parameter int          CNT_W    = 16,
   parameter logic [31:0] SIG_INIT = SIG_INIT_DEF,
   parameter logic [31:0] SIG_POLY = SIG_POLY_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [63:0]      seed,
   input  logic [CNT_W-1:0] num_vec,
   output logic [IN_W-1:0]  stim,
   input  logic [OUT_W-1:0] resp,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] vec_cnt,
`ifdef STIM_RESP_DUAL_EN
   input  logic [OUT_W-1:0] resp_b,
   output logic [31:0]      signature_b,
   output logic             mismatch,
   output logic [CNT_W-1:0] first_bad,
`endif
   output logic [31:0]      signature
);

   localparam int N_CHUNK = (IN_W + 63) / 64;
   localparam int HOLD_W  = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD - 1);

   state_e               state_q;
   logic [63:0]          lfsr_q;
   logic [63:0]          lfsr_d;
   logic [IN_W-1:0]      stim_q;
   logic [IN_W-1:0]      stim_d;
   logic [N_CHUNK*64-1:0] gen_all;
   logic [CNT_W-1:0]     vec_cnt_q;
   logic [CNT_W-1:0]     num_vec_q;
   logic [HOLD_W-1:0]    hold_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 accept;
   logic                 capture;
   logic                 last_vec;
   logic [63:0]          seed_eff;

   assign accept   = (state_q == ST_IDLE) && start && (num_vec != '0);
   assign capture  = (state_q == ST_CAPTURE);
   assign last_vec = (vec_cnt_q == num_vec_q - CNT_W'(1));
   assign seed_eff = (seed == '0) ? 64'h1 : seed;

   // One LFSR step and the stimulus generated from the stepped state:
   // chunk k is the state rotated left by 7k, XORed with k.
   always_comb begin
      lfsr_d  = {lfsr_q[62:0], ^(lfsr_q & LFSR_TAP_MASK)};
      gen_all = '0;
      for (int k = 0; k < N_CHUNK; k++) begin
         gen_all[k*64 +: 64] = ((lfsr_d << ((7 * k) % 64))
                                | (lfsr_d >> ((64 - (7 * k) % 64) % 64)))
                               ^ 64'(k);
      end
      stim_d = IN_W'(gen_all);
   end

   // Run sequencer: accept, settle for HOLD cycles, capture, advance or finish.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         lfsr_q    <= 64'h1;
         stim_q    <= '0;
         vec_cnt_q <= '0;
         num_vec_q <= '0;
         hold_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  lfsr_q    <= seed_eff;
                  stim_q    <= '0;
                  vec_cnt_q <= '0;
                  num_vec_q <= num_vec;
                  hold_q    <= HOLD_LOAD;
                  busy_q    <= 1'b1;
                  state_q   <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (hold_q == '0) state_q <= ST_CAPTURE;
               else              hold_q  <= hold_q - HOLD_W'(1);
            end
            ST_CAPTURE: begin
               if (last_vec) begin
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  lfsr_q    <= lfsr_d;
                  stim_q    <= stim_d;
                  vec_cnt_q <= vec_cnt_q + CNT_W'(1);
                  hold_q    <= HOLD_LOAD;
                  state_q   <= ST_SETTLE;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   stim_misr32 #(
      .DATA_W   (OUT_W),
      .SIG_INIT (SIG_INIT),
      .SIG_POLY (SIG_POLY)
   ) u_misr_a (
      .clk    (clk),
      .rst    (rst),
      .load_i (accept),
      .en_i   (capture),
      .data_i (resp),
      .sig_o  (signature)
   );

`ifdef STIM_RESP_DUAL_EN
   logic             mismatch_q;
   logic [CNT_W-1:0] first_bad_q;

   stim_misr32 #(
      .DATA_W   (OUT_W),
      .SIG_INIT (SIG_INIT),
      .SIG_POLY (SIG_POLY)
   ) u_misr_b (
      .clk    (clk),
      .rst    (rst),
      .load_i (accept),
      .en_i   (capture),
      .data_i (resp_b),
      .sig_o  (signature_b)
   );

   // Sticky compare of the two responses; first_bad latches the first
   // mismatching vector of the current run.
   always_ff @(posedge clk) begin
      if (rst || accept) begin
         mismatch_q  <= 1'b0;
         first_bad_q <= '0;
      end else if (capture && (resp != resp_b) && !mismatch_q) begin
         mismatch_q  <= 1'b1;
         first_bad_q <= vec_cnt_q;
      end
   end

   assign mismatch  = mismatch_q;
   assign first_bad = first_bad_q;
`endif

   assign stim    = stim_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign vec_cnt = vec_cnt_q;

endmodule

// File: tb/tb_stim_resp_engine.sv
// Scoreboard bench for stim_resp_engine: the driver computes each run's
// vector sequence and final signature from a behavioural model and queues
// them; a negedge monitor pops and compares as the DUT presents vectors/done.
module tb_stim_resp_engine;

   localparam int          IN_W     = 83;
   localparam int          OUT_W    = 245;
   localparam int          HOLD     = 4;
   localparam int          CNT_W    = 16;
   localparam int          NCH      = (IN_W + 63) / 64;
   localparam int          RCH      = (OUT_W + 31) / 32;
   localparam logic [31:0] SIG_INIT = 32'hFFFFFFFF;
   localparam logic [31:0] SIG_POLY = 32'h04C11DB7;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [63:0]      seed;
   logic [CNT_W-1:0] num_vec;
   logic [IN_W-1:0]  stim;
   logic [OUT_W-1:0] resp;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] vec_cnt;
   logic [31:0]      signature;
   logic [IN_W-1:0]  key;
`ifdef STIM_RESP_DUAL_EN
   logic [OUT_W-1:0] resp_b;
   logic [31:0]      signature_b;
   logic             mismatch;
   logic [CNT_W-1:0] first_bad;
   int               flip_at = -1;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [CNT_W-1:0] idx;
      logic [IN_W-1:0]  stim;
   } vec_t;

   typedef struct {
      int          nv;
      logic [31:0] sig;
      logic [31:0] sig_b;
      logic        mm;
      int          fb;
   } run_t;

   vec_t vec_q[$];
   run_t run_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   stim_resp_engine #(
      .IN_W (IN_W), .OUT_W (OUT_W), .HOLD (HOLD), .CNT_W (CNT_W),
      .SIG_INIT (SIG_INIT), .SIG_POLY (SIG_POLY)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .seed      (seed),
      .num_vec   (num_vec),
      .stim      (stim),
      .resp      (resp),
      .busy      (busy),
      .done      (done),
      .vec_cnt   (vec_cnt),
`ifdef STIM_RESP_DUAL_EN
      .resp_b      (resp_b),
      .signature_b (signature_b),
      .mismatch    (mismatch),
      .first_bad   (first_bad),
`endif
      .signature (signature)
   );

   // ---------------- behavioural model ----------------
   // Response of the modelled DUT: a fixed mix of the stimulus and a per-run key.
   function automatic logic [OUT_W-1:0] resp_fn(input logic [IN_W-1:0] s,
                                                input logic [IN_W-1:0] k);
      logic [3*IN_W-1:0] x;
      x = {{s[IN_W/2-1:0], s[IN_W-1:IN_W/2]}, s ^ k, s};
      return x[OUT_W-1:0];
   endfunction

   assign resp = resp_fn(stim, key);
`ifdef STIM_RESP_DUAL_EN
   assign resp_b = resp ^ OUT_W'((flip_at >= 0 && int'(vec_cnt) == flip_at) ? 1 : 0);
`endif

   function automatic logic [63:0] lfsr_step(input logic [63:0] s);
      logic fb;
      fb = s[63] ^ s[62] ^ s[60] ^ s[59];
      return {s[62:0], fb};
   endfunction

   function automatic logic [IN_W-1:0] gen_model(input logic [63:0] s);
      logic [NCH*64-1:0] all;
      logic [63:0]       rot;
      int                r;
      for (int k = 0; k < NCH; k++) begin
         r = (7 * k) % 64;
         for (int i = 0; i < 64; i++) rot[i] = s[(i - r + 64) % 64];
         all[k*64 +: 64] = rot ^ 64'(k);
      end
      return all[IN_W-1:0];
   endfunction

   function automatic logic [31:0] fold_model(input logic [OUT_W-1:0] r);
      logic [RCH*32-1:0] x;
      logic [31:0]       acc;
      x   = '0;
      x[OUT_W-1:0] = r;
      acc = '0;
      for (int i = 0; i < RCH; i++) acc ^= 32'(x >> (32 * i));
      return acc;
   endfunction

   function automatic logic [31:0] misr_model(input logic [31:0] sg, input logic [31:0] f);
      logic [31:0] nx;
      nx = sg << 1;
      if (sg[31]) nx ^= SIG_POLY;
      return nx ^ f;
   endfunction

   // Queue the vectors a run will show (0..last_idx) and, if it completes,
   // its final result.
   task automatic expect_run(input logic [63:0] sd, input int nv, input int last_idx,
                             input bit completes);
      logic [63:0]      s;
      logic [IN_W-1:0]  st;
      logic [OUT_W-1:0] r;
      logic [OUT_W-1:0] rb;
      vec_t             ve;
      run_t             re;
      s  = (sd == 64'h0) ? 64'h1 : sd;
      st = '0;
      re.nv = nv; re.sig = SIG_INIT; re.sig_b = SIG_INIT; re.mm = 1'b0; re.fb = 0;
      for (int v = 0; v < nv; v++) begin
         if (v <= last_idx) begin
            ve.idx = CNT_W'(v); ve.stim = st;
            vec_q.push_back(ve);
         end
         r  = resp_fn(st, key);
         rb = r;
`ifdef STIM_RESP_DUAL_EN
         if (v == flip_at) rb[0] = ~rb[0];
`endif
         if (rb != r && !re.mm) begin re.mm = 1'b1; re.fb = v; end
         re.sig   = misr_model(re.sig, fold_model(r));
         re.sig_b = misr_model(re.sig_b, fold_model(rb));
         if (v < nv - 1) begin
            s  = lfsr_step(s);
            st = gen_model(s);
         end
      end
      if (completes) run_q.push_back(re);
   endtask

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   initial begin : monitor
      logic             busy_p;
      logic             done_p;
      logic [CNT_W-1:0] vc_p;
      int               acc_cyc;
      vec_t             ve;
      run_t             re;
      busy_p = 1'b0; done_p = 1'b0; vc_p = '0; acc_cyc = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (busy && (!busy_p || vec_cnt != vc_p)) begin
               if (!busy_p) acc_cyc = cyc;
               check("vec_expected", vec_q.size() != 0, 1'b1);
               if (vec_q.size() != 0) begin
                  ve = vec_q.pop_front();
                  check("vec_idx", vec_cnt, ve.idx);
                  check("vec_stim", stim, ve.stim);
               end
            end
            if (done) begin
               check("done_expected", run_q.size() != 0, 1'b1);
               if (run_q.size() != 0) begin
                  re = run_q.pop_front();
                  check("done_latency", cyc - acc_cyc, re.nv * (HOLD + 1));
                  check("signature", signature, re.sig);
                  check("done_vec_cnt", vec_cnt, re.nv - 1);
                  check("done_busy", busy, 1'b1);
`ifdef STIM_RESP_DUAL_EN
                  check("signature_b", signature_b, re.sig_b);
                  check("mismatch", mismatch, re.mm);
                  if (re.mm) check("first_bad", first_bad, re.fb);
`endif
               end
            end
            if (done_p) begin
               check("done_one_cycle", done, 1'b0);
               check("busy_drops_after_done", busy, 1'b0);
            end
         end
         busy_p = rst ? 1'b0 : busy;
         done_p = rst ? 1'b0 : done;
         vc_p   = vec_cnt;
      end
   end

   // ---------------- driver ----------------
   task automatic start_run(input logic [63:0] sd, input int nv);
      @(negedge clk);
      seed = sd; num_vec = CNT_W'(nv); start = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      seed    = {$urandom, $urandom};
      num_vec = CNT_W'($urandom);
   endtask

   task automatic wait_end(input string name, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         if (seen && !busy) break;
      end
      check({name, "_completed"}, seen && !busy, 1'b1);
   endtask

   task automatic wait_vec(input string name, input int target, input int budget);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge clk);
         if (busy && int'(vec_cnt) == target) hit = 1'b1;
      end
      check({name, "_reached"}, hit, 1'b1);
   endtask

   task automatic check_reset_state(input string name);
      check({name, "_stim"}, stim, '0);
      check({name, "_signature"}, signature, SIG_INIT);
      check({name, "_vec_cnt"}, vec_cnt, '0);
      check({name, "_busy"}, busy, 1'b0);
      check({name, "_done"}, done, 1'b0);
   endtask

   initial begin : watchdog
      #500_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      logic [63:0] sd;
      bit          flag;
      int          nv;
      rst = 1'b1; start = 1'b0; seed = '0; num_vec = '0; key = '0;
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;

      // Null run: num_vec = 0 is never accepted.
      flag = 1'b0;
      seed = 64'h1234; num_vec = '0; start = 1'b1;
      repeat (20) begin
         @(negedge clk);
         flag |= busy | done;
      end
      start = 1'b0;
      check("null_busy_done", flag, 1'b0);
      check("null_signature", signature, 32'hFFFFFFFF);

      // Single vector with an all-zero response.
      key = '0;
      expect_run(64'h5, 1, 0, 1'b1);
      start_run(64'h5, 1);
      wait_end("single", 40);
      check("single_signature_const", signature, 32'hFB3EE249);
      check("single_stim_zero", stim, '0);

      // Generation from seed 1: vector 1 comes from the stepped LFSR (2).
      key = IN_W'({$urandom, $urandom, $urandom});
      expect_run(64'h1, 2, 1, 1'b1);
      start_run(64'h1, 2);
      wait_vec("gen_vec1", 1, 40);
      check("gen_chunk0", stim[63:0], 64'h2);
      wait_end("gen", 40);

      // Seed 0 behaves as seed 1.
      expect_run(64'h0, 4, 3, 1'b1);
      start_run(64'h0, 4);
      wait_end("seed0", 100);

      // Randomized runs.
      for (int r = 0; r < 6; r++) begin
         key = IN_W'({$urandom, $urandom, $urandom});
         sd  = {$urandom, $urandom};
         nv  = $urandom_range(1, 12);
         expect_run(sd, nv, nv - 1, 1'b1);
         start_run(sd, nv);
         wait_end("random", nv * (HOLD + 1) + 20);
      end

      // start/num_vec toggled during a run have no effect.
      sd = {$urandom, $urandom};
      expect_run(sd, 8, 7, 1'b1);
      start_run(sd, 8);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (int'(vec_cnt) == 7 || !busy) break;
         start   = 1'($urandom);
         num_vec = CNT_W'($urandom);
      end
      start = 1'b0;
      wait_end("ignored_inputs", 60);

      // Abort at vector 10 of 21, then two identical reruns.
      key = IN_W'({$urandom, $urandom, $urandom});
      sd  = {$urandom, $urandom};
      expect_run(sd, 21, 10, 1'b0);
      start_run(sd, 21);
      wait_vec("abort_vec10", 10, 200);
      rst = 1'b1;
      @(negedge clk);
      check_reset_state("abort");
      check("abort_vectors_consumed", vec_q.size(), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_idle_busy", busy, 1'b0);
      for (int r = 0; r < 2; r++) begin
         expect_run(sd, 21, 20, 1'b1);
         start_run(sd, 21);
         wait_end("rerun", 21 * (HOLD + 1) + 20);
      end

`ifdef STIM_RESP_DUAL_EN
      // Second response differs at vector 3 only, then a clean rerun.
      flip_at = 3;
      expect_run(sd, 6, 5, 1'b1);
      start_run(sd, 6);
      wait_end("dual_bad", 60);
      check("dual_sig_differs", signature_b != signature, 1'b1);
      flip_at = -1;
      expect_run(sd, 6, 5, 1'b1);
      start_run(sd, 6);
      wait_end("dual_clean", 60);
      check("dual_clean_mismatch", mismatch, 1'b0);
`endif

      repeat (2) @(negedge clk);
      check("vec_q_drained", vec_q.size(), 0);
      check("run_q_drained", run_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
